// File: rtl/iob_ctls_stream_pkg.sv
// iob_ctls_stream_pkg: shared state, mode and symbol encodings for the streaming symbol counter
package iob_ctls_stream_pkg;
    typedef enum logic {SCAN = 1'b0, RESULT = 1'b1} state_t;
    localparam logic TRAILING = 1'b0;
    localparam logic LEADING = 1'b1;
    localparam logic ZEROS = 1'b0;
    localparam logic ONES = 1'b1;
endpackage

// File: rtl/iob_ctls_word.sv
// iob_ctls_word: combinational count of consecutive symbol bits in one beat (0..W)
module iob_ctls_word
    import iob_ctls_stream_pkg::*;
#(
    parameter int W = 32,
    localparam int WC_W = $clog2(W + 1)
) (
    input  logic [W-1:0]    data_i,
    input  logic            mode_i,
    input  logic            symbol_i,
    output logic [WC_W-1:0] count_o
);
    logic [W-1:0] inv, scan;

    always_comb begin
        inv = symbol_i == ONES ? ~data_i : data_i;
        for (int i = 0; i < W; i++) scan[i] = mode_i == LEADING ? inv[W-1-i] : inv[i];
        // lowest set bit ends the run; no set bit means the whole beat matched
        count_o = WC_W'(W);
        for (int i = W - 1; i >= 0; i--) if (scan[i]) count_o = WC_W'(i);
    end
endmodule

// File: rtl/iob_ctls_stream.sv
// iob_ctls_stream: multi-beat leading/trailing zero/one counter between valid/ready streams.
// Optional IOB_CTLS_STREAM_BEAT_CNT_EN exposes the accepted-beat count on beats_o.
module iob_ctls_stream
    import iob_ctls_stream_pkg::*;
#(
    parameter int W = 32,
    parameter int MAX_WORDS = 16,
    localparam int CNT_W = $clog2(W * MAX_WORDS + 1),
    localparam int BEAT_W = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk_i,
    input  logic             cke_i,
    input  logic             rst_i,
    input  logic             mode_i,
    input  logic             symbol_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    input  logic [W-1:0]     data_i,
    input  logic             data_last_i,
    output logic             count_valid_o,
    input  logic             count_ready_i,
    output logic [CNT_W-1:0] count_o,
`ifdef IOB_CTLS_STREAM_BEAT_CNT_EN
    output logic [BEAT_W-1:0] beats_o,
`endif
    output logic             err_o
);
    localparam int WC_W = $clog2(W + 1);

    state_t state_q;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [BEAT_W-1:0] beat_q;
    logic found_q, err_q, mode_q, sym_q;
    logic first, at_max, counting, accept;
    logic [WC_W-1:0] wc;

    assign first = beat_q == '0;
    assign at_max = beat_q == BEAT_W'(MAX_WORDS);
    assign counting = !found_q && !at_max;
    assign data_ready_o = cke_i && state_q != RESULT;
    assign accept = data_valid_i && data_ready_o;
    assign acc_d = acc_q + (counting ? CNT_W'(wc) : '0);

    iob_ctls_word #(.W(W)) u_word (
        .data_i  (data_i),
        .mode_i  (first ? mode_i : mode_q),
        .symbol_i(first ? symbol_i : sym_q),
        .count_o (wc)
    );

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                state_q <= SCAN;
                acc_q <= '0;
                beat_q <= '0;
                found_q <= 1'b0;
                err_q <= 1'b0;
                mode_q <= 1'b0;
                sym_q <= 1'b0;
            end else if (state_q == SCAN) begin
                if (accept) begin
                    if (first) begin
                        mode_q <= mode_i;
                        sym_q <= symbol_i;
                    end
                    acc_q <= acc_d;
                    found_q <= found_q || (counting && wc != WC_W'(W));
                    beat_q <= at_max ? beat_q : beat_q + 1'b1;
                    err_q <= err_q || at_max;
                    if (data_last_i) state_q <= RESULT;
                end
            end else if (count_ready_i) begin
                state_q <= SCAN;
                acc_q <= '0;
                beat_q <= '0;
                found_q <= 1'b0;
                err_q <= 1'b0;
            end
        end
    end

    assign count_valid_o = state_q == RESULT;
    assign count_o = acc_q;
    assign err_o = err_q;
`ifdef IOB_CTLS_STREAM_BEAT_CNT_EN
    assign beats_o = beat_q;
`endif
endmodule

// File: tb/tb_iob_ctls_stream.sv
// tb_iob_ctls_stream: directed plus randomized frames checked against a bit-sequence reference model
module tb_iob_ctls_stream;
    localparam int W = 8;
    localparam int MW = 4;
    localparam int CNT_W = 6;
    localparam int BEAT_W = 3;

    logic clk_i = 1'b0, cke_i = 1'b1, rst_i = 1'b1;
    logic mode_i = 1'b0, symbol_i = 1'b0, data_valid_i = 1'b0, data_last_i = 1'b0, count_ready_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic data_ready_o, count_valid_o, err_o;
    logic [CNT_W-1:0] count_o;
`ifdef IOB_CTLS_STREAM_BEAT_CNT_EN
    logic [BEAT_W-1:0] beats_o;
`endif

    iob_ctls_stream #(.W(W), .MAX_WORDS(MW)) dut (
        .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .mode_i(mode_i), .symbol_i(symbol_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .data_last_i(data_last_i), .count_valid_o(count_valid_o), .count_ready_i(count_ready_i),
        .count_o(count_o),
`ifdef IOB_CTLS_STREAM_BEAT_CNT_EN
        .beats_o(beats_o),
`endif
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0, checks = 0;
    logic [W-1:0] frame[$];
    bit fm, fs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Frame viewed as one long bit stream in scan order, truncated to MW beats
    function automatic int model_count();
        int c = 0;
        bit run = 1;
        for (int k = 0; k < frame.size() && k < MW; k++)
            for (int j = 0; j < W; j++) begin
                if (run && frame[k][fm ? W-1-j : j] == fs) c++;
                else run = 0;
            end
        return c;
    endfunction

    task automatic send_frame(input bit use_last, input bit chaos);
        for (int k = 0; k < frame.size(); k++) begin
            int t = 0;
            @(negedge clk_i);
            if (chaos && $urandom_range(0, 2) == 0) begin
                data_valid_i = 1'b0;
                @(negedge clk_i);
            end
            data_valid_i = 1'b1;
            data_i = frame[k];
            data_last_i = use_last && k == frame.size() - 1;
            mode_i = (k > 0 && chaos) ? 1'($urandom) : fm;
            symbol_i = (k > 0 && chaos) ? 1'($urandom) : fs;
            while (!data_ready_o && t < 50) begin
                @(negedge clk_i);
                t++;
            end
            if (t == 50) begin
                chk("ready_timeout", 0, 1);
                data_valid_i = 1'b0;
                return;
            end
            @(posedge clk_i);
        end
        @(negedge clk_i);
        data_valid_i = 1'b0;
        data_last_i = 1'b0;
    endtask

    task automatic get_result(input string tag, input int hold);
        int t = 0;
        int exp_cnt = model_count();
        logic [CNT_W-1:0] held;
        while (!count_valid_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        chk({tag, "_latency"}, t, 0);
        chk({tag, "_count"}, count_o, exp_cnt);
        chk({tag, "_err"}, err_o, frame.size() > MW);
`ifdef IOB_CTLS_STREAM_BEAT_CNT_EN
        chk({tag, "_beats"}, beats_o, frame.size() > MW ? MW : frame.size());
`endif
        held = count_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            chk({tag, "_hold_count"}, count_o, held);
            chk({tag, "_hold_ready"}, data_ready_o, 0);
        end
        count_ready_i = 1'b1;
        @(negedge clk_i);
        count_ready_i = 1'b0;
        chk({tag, "_valid_clr"}, count_valid_o, 0);
        chk({tag, "_ready_back"}, data_ready_o, 1);
    endtask

    task automatic run(input string tag, input bit m, input bit s, input int hold);
        fm = m;
        fs = s;
        send_frame(1, 0);
        get_result(tag, hold);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_valid", count_valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_ready", data_ready_o, 1);

        frame = '{8'h08};
        run("t1", 0, 0, 0);
        frame = '{8'hFF, 8'hFF, 8'hF0};
        run("t2", 1, 1, 0);
        frame = '{8'h00, 8'h00, 8'h00, 8'h00};
        run("t3", 0, 0, 0);
        frame = '{8'h01, 8'h00, 8'h00};
        run("t4", 0, 0, 0);
        frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run("t5", 0, 0, 0);
        frame = '{8'h80, 8'h00};
        run("t6", 1, 0, 5);

        // clock enable low in RESULT: no handshake, outputs frozen
        frame = '{8'h3F};
        fm = 0;
        fs = 1;
        send_frame(1, 0);
        cke_i = 1'b0;
        count_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("cke_valid", count_valid_o, 1);
        chk("cke_ready", data_ready_o, 0);
        chk("cke_count", count_o, 6);
        count_ready_i = 1'b0;
        cke_i = 1'b1;
        get_result("cke", 0);

        // reset in the middle of a frame discards it
        frame = '{8'hFF, 8'hFF};
        fm = 1;
        fs = 1;
        send_frame(0, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("mid_rst_valid", count_valid_o, 0);
        chk("mid_rst_count", count_o, 0);
        frame = '{8'h0F};
        run("post_rst", 0, 1, 0);

        for (int n = 0; n < 40; n++) begin
            int len = $urandom_range(1, 6);
            fm = 1'($urandom);
            fs = 1'($urandom);
            frame.delete();
            for (int k = 0; k < len; k++)
                frame.push_back($urandom_range(0, 1) ? {W{fs}} : W'($urandom));
            send_frame(1, 1);
            get_result("rnd", $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
